amo_mem_unit: RTL

- MEM-stage atomic execution unit. It consumes the EX stage's amo_valid/amo_op/amo_rs2_data plus the ALU address, and runs the LR.W/SC.W/AMO*.W memory sequences on the data-memory port.
- It returns amo_result/amo_done to EX, and to the MEM/WB path, and keeps the single LR/SC reservation.
- While an atomic is in flight, it holds the pipeline through stall_o.

---
 rtl/amo_mem_if.sv | 25 ++
 rtl/amo_mem_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/amo_mem_if.sv
// Data-memory port used by the atomic unit: a request channel with valid/ready
// handshake and a response channel carrying read data or a write acknowledge.
interface amo_mem_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic            mem_req_we_o;
  logic [XLEN-1:0] mem_req_addr_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic [3:0]      mem_req_wmask_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_rdata_i;
  logic            mem_rsp_err_i;

  modport master (
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i
  );
endinterface

// File: rtl/amo_mem_unit.sv
// MEM-stage atomic unit: sequences LR.W / SC.W / AMO*.W on the data-memory port,
// owns the single LR/SC reservation and stalls the pipeline while busy.
module amo_mem_unit #(
  parameter int XLEN      = 32,
  parameter int AMOOP_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 amo_valid_i,
  input  logic [AMOOP_LEN-1:0] amo_op_i,
  input  logic [XLEN-1:0]      amo_addr_i,
  input  logic [XLEN-1:0]      amo_rs2_data_i,
  input  logic                 flush_i,
  input  logic                 st_snoop_valid_i,
  input  logic [XLEN-1:0]      st_snoop_addr_i,
  amo_mem_if.master            mem,
  output logic [XLEN-1:0]      amo_result_o,
  output logic                 amo_done_o,
  output logic                 amo_access_fault_o,
  output logic                 stall_o
);

  localparam logic [AMOOP_LEN-1:0] OP_NONE = AMOOP_LEN'(0);
  localparam logic [AMOOP_LEN-1:0] OP_LR   = AMOOP_LEN'(1);
  localparam logic [AMOOP_LEN-1:0] OP_SC   = AMOOP_LEN'(2);
  localparam logic [AMOOP_LEN-1:0] OP_ADD  = AMOOP_LEN'(4);
  localparam logic [AMOOP_LEN-1:0] OP_XOR  = AMOOP_LEN'(5);
  localparam logic [AMOOP_LEN-1:0] OP_AND  = AMOOP_LEN'(6);
  localparam logic [AMOOP_LEN-1:0] OP_OR   = AMOOP_LEN'(7);
  localparam logic [AMOOP_LEN-1:0] OP_MIN  = AMOOP_LEN'(8);
  localparam logic [AMOOP_LEN-1:0] OP_MAX  = AMOOP_LEN'(9);
  localparam logic [AMOOP_LEN-1:0] OP_MINU = AMOOP_LEN'(10);
  localparam logic [AMOOP_LEN-1:0] OP_MAXU = AMOOP_LEN'(11);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   drain_q, drain_d;
  logic [AMOOP_LEN-1:0]   op_q;
  logic [XLEN-3:0]        addr_word_q;
  logic [XLEN-1:0]        rs2_q, old_q, wdata_q, result_q;
  logic                   fault_q;
  logic                   resv_valid_q;
  logic [XLEN-3:0]        resv_word_q;

  logic                   accept, misaligned, resv_hit, snoop_hit, sc_clear;
  logic                   res_we, fault_d, lr_set, load_new;
  logic [XLEN-1:0]        res_d, new_val;

  assign accept     = (state_q == S_IDLE) && amo_valid_i && (amo_op_i != OP_NONE) && !flush_i;
  assign misaligned = (amo_addr_i[1:0] != 2'b00);
  assign resv_hit   = resv_valid_q && (amo_addr_i[XLEN-1:2] == resv_word_q);
  assign snoop_hit  = st_snoop_valid_i && resv_valid_q &&
                      ((st_snoop_addr_i >> 2) == {2'b00, resv_word_q});
  assign sc_clear   = accept && (amo_op_i == OP_SC);

  // Value to store back, from the word just read and the latched rs2.
  always_comb begin
    case (op_q)
      OP_ADD:  new_val = mem.mem_rsp_rdata_i + rs2_q;
      OP_XOR:  new_val = mem.mem_rsp_rdata_i ^ rs2_q;
      OP_AND:  new_val = mem.mem_rsp_rdata_i & rs2_q;
      OP_OR:   new_val = mem.mem_rsp_rdata_i | rs2_q;
      OP_MIN:  new_val = ($signed(mem.mem_rsp_rdata_i) < $signed(rs2_q)) ? mem.mem_rsp_rdata_i : rs2_q;
      OP_MAX:  new_val = ($signed(mem.mem_rsp_rdata_i) > $signed(rs2_q)) ? mem.mem_rsp_rdata_i : rs2_q;
      OP_MINU: new_val = (mem.mem_rsp_rdata_i < rs2_q) ? mem.mem_rsp_rdata_i : rs2_q;
      OP_MAXU: new_val = (mem.mem_rsp_rdata_i > rs2_q) ? mem.mem_rsp_rdata_i : rs2_q;
      default: new_val = rs2_q;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    res_we   = 1'b0;
    res_d    = '0;
    fault_d  = 1'b0;
    lr_set   = 1'b0;
    load_new = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d = S_DONE;
            res_we  = 1'b1;
          end else if (amo_op_i == OP_SC) begin
            if (resv_hit) begin
              state_d = S_WR_REQ;
            end else begin
              state_d = S_DONE;
              res_we  = 1'b1;
              res_d   = XLEN'(1);
            end
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (flush_i)                   state_d = S_IDLE;
        else if (mem.mem_req_ready_i)  state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem.mem_rsp_valid_i) begin
          drain_d = 1'b0;
          if (drain_q || flush_i) begin
            state_d = S_IDLE;
          end else if (mem.mem_rsp_err_i) begin
            state_d = S_DONE;
            res_we  = 1'b1;
            fault_d = 1'b1;
          end else if (op_q == OP_LR) begin
            state_d = S_DONE;
            res_we  = 1'b1;
            res_d   = mem.mem_rsp_rdata_i;
            lr_set  = 1'b1;
          end else begin
            state_d  = S_WR_REQ;
            load_new = 1'b1;
          end
        end else if (flush_i) begin
          drain_d = 1'b1;
        end
      end
      S_WR_REQ: begin
        if (flush_i)                   state_d = S_IDLE;
        else if (mem.mem_req_ready_i)  state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem.mem_rsp_valid_i) begin
          drain_d = 1'b0;
          if (drain_q || flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            res_we  = 1'b1;
            res_d   = (op_q == OP_SC) ? '0 : old_q;
            fault_d = mem.mem_rsp_err_i;
          end
        end else if (flush_i) begin
          drain_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: datapath registers are reset too because they drive the bus and
  // result outputs directly, which must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q         <= OP_NONE;
      addr_word_q  <= '0;
      rs2_q        <= '0;
      old_q        <= '0;
      wdata_q      <= '0;
      result_q     <= '0;
      fault_q      <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_word_q  <= '0;
    end else begin
      if (accept) begin
        op_q        <= amo_op_i;
        addr_word_q <= amo_addr_i[XLEN-1:2];
        rs2_q       <= amo_rs2_data_i;
        wdata_q     <= amo_rs2_data_i;
      end
      if (load_new) begin
        old_q   <= mem.mem_rsp_rdata_i;
        wdata_q <= new_val;
      end
      if (res_we) begin
        result_q <= res_d;
        fault_q  <= fault_d;
      end
      // An LR completing this cycle takes priority over a snooped store.
      if (lr_set) begin
        resv_valid_q <= 1'b1;
        resv_word_q  <= addr_word_q;
      end else if (flush_i || sc_clear || snoop_hit) begin
        resv_valid_q <= 1'b0;
      end
    end
  end

  assign mem.mem_req_valid_o = ((state_q == S_RD_REQ) || (state_q == S_WR_REQ)) && !flush_i;
  assign mem.mem_req_we_o    = (state_q == S_WR_REQ);
  assign mem.mem_req_addr_o  = {addr_word_q, 2'b00};
  assign mem.mem_req_wdata_o = wdata_q;
  assign mem.mem_req_wmask_o = (state_q == S_WR_REQ) ? 4'hF : 4'h0;

  assign amo_done_o         = (state_q == S_DONE);
  assign amo_access_fault_o = amo_done_o && fault_q;
  assign amo_result_o       = result_q;
  assign stall_o            = amo_valid_i && !amo_done_o;

endmodule
